// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_data_t  : IF -> IF/ID payload {valid, pc, raw_instr}
//   fetch_state_t : fetch FSM states
//   pc_sel_t      : next-PC source selector used by fetch_pc_reg
package fetch_unit_pkg;

  localparam int unsigned FETCH_ADDR_W  = 64;
  localparam int unsigned FETCH_INSTR_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_PC_RESET = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic                     valid;
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] raw_instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_KEEP = 2'd0,
    PC_INC  = 2'd1,
    PC_JUMP = 2'd2,
    PC_PEND = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// PC register with next-PC mux.
//   clk, reset        : clock, synchronous active-high reset
//   i_sel             : next-PC source (keep / +4 / jump_target / pending_target)
//   i_jump_target     : redirect PC, word-aligned here on capture
//   i_pending_target  : redirect PC captured earlier (already aligned)
//   o_pc              : current PC
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0]    PC_RESET = ADDR_W'(FETCH_PC_RESET)
) (
  input  logic              clk,
  input  logic              reset,
  input  pc_sel_t           i_sel,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic [ADDR_W-1:0] i_pending_target,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;

  // Next-PC select; +4 wraps naturally modulo 2^ADDR_W.
  always_comb begin
    w_pc_nxt = r_pc;
    case (i_sel)
      PC_INC:  w_pc_nxt = r_pc + ADDR_W'(4);
      PC_JUMP: w_pc_nxt = {i_jump_target[ADDR_W-1:2], 2'b00};
      PC_PEND: w_pc_nxt = i_pending_target;
      default: w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_pc <= PC_RESET;
    else       r_pc <= w_pc_nxt;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the instruction-bus handshake,
// buffers a word while decode is load-stalled and handles redirects,
// including one arriving while a request is still outstanding.
//   clk, reset          : clock, synchronous active-high reset
//   o_ireq_valid        : instruction request valid (REQ, DISCARD)
//   o_ireq_addr         : request address, stable until data_ok
//   i_iresp_data_ok     : one-cycle response strobe
//   i_iresp_data        : instruction word
//   i_jump_flag         : redirect from execute
//   i_jump_target       : redirect PC
//   i_load_stall        : decode load-use stall
//   o_dataF_nxt         : {valid, pc, raw_instr} to IF/ID (combinational)
//   o_handshake_stall   : fetch waiting on bus (combinational)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [FETCH_ADDR_W-1:0] PC_RESET = FETCH_PC_RESET,
  parameter int unsigned             ADDR_W   = FETCH_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     o_ireq_valid,
  output logic [ADDR_W-1:0]        o_ireq_addr,
  input  logic                     i_iresp_data_ok,
  input  logic [FETCH_INSTR_W-1:0] i_iresp_data,
  input  logic                     i_jump_flag,
  input  logic [ADDR_W-1:0]        i_jump_target,
  input  logic                     i_load_stall,
  output fetch_data_t              o_dataF_nxt,
  output logic                     o_handshake_stall
);

  fetch_state_t             r_state;
  fetch_state_t             w_state_nxt;
  logic [FETCH_INSTR_W-1:0] r_buffer;
  logic [ADDR_W-1:0]        r_pending_target;
  logic [ADDR_W-1:0]        w_pc;
  pc_sel_t                  w_pc_sel;
  logic                     w_buf_load;
  logic                     w_pend_load;
  fetch_data_t              w_data;
  logic                     w_stall;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (ADDR_W'(PC_RESET))
  ) u_pc_reg (
    .clk              (clk),
    .reset            (reset),
    .i_sel            (w_pc_sel),
    .i_jump_target    (i_jump_target),
    .i_pending_target (r_pending_target),
    .o_pc             (w_pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= REQ;
    else       r_state <= w_state_nxt;
  end

  // Next state, PC select and combinational outputs. jump beats load_stall.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_sel    = PC_KEEP;
    w_buf_load  = 1'b0;
    w_pend_load = 1'b0;
    w_data      = '0;
    w_stall     = 1'b0;
    case (r_state)
      REQ: begin
        if (i_iresp_data_ok) begin
          if (i_jump_flag) begin
            w_pc_sel = PC_JUMP;
          end else if (i_load_stall) begin
            w_buf_load  = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_data   = '{valid: 1'b1, pc: FETCH_ADDR_W'(w_pc), raw_instr: i_iresp_data};
            w_pc_sel = PC_INC;
          end
        end else begin
          w_stall = 1'b1;
          if (i_jump_flag) begin
            // Request already on the bus: let it finish, then redirect.
            w_pend_load = 1'b1;
            w_state_nxt = DISCARD;
          end
        end
      end
      HOLD: begin
        w_data = '{valid: 1'b1, pc: FETCH_ADDR_W'(w_pc), raw_instr: r_buffer};
        if (i_jump_flag) begin
          w_pc_sel    = PC_JUMP;
          w_state_nxt = REQ;
        end else if (!i_load_stall) begin
          w_pc_sel    = PC_INC;
          w_state_nxt = REQ;
        end
      end
      DISCARD: begin
        // Repeated jump_flag here is the same held redirect; ignore it.
        if (i_iresp_data_ok) begin
          w_pc_sel    = PC_PEND;
          w_state_nxt = REQ;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // Buffered word and deferred redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buffer         <= '0;
      r_pending_target <= '0;
    end else begin
      if (w_buf_load)  r_buffer         <= i_iresp_data;
      if (w_pend_load) r_pending_target <= {i_jump_target[ADDR_W-1:2], 2'b00};
    end
  end

  assign o_ireq_valid      = !reset && ((r_state == REQ) || (r_state == DISCARD));
  assign o_ireq_addr       = w_pc;
  assign o_dataF_nxt       = reset ? '0 : w_data;
  assign o_handshake_stall = !reset && w_stall;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        jump_flag;
  logic [63:0] jump_target;
  logic        load_stall;
  fetch_data_t dataF_nxt;
  logic        handshake_stall;

  fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .o_ireq_valid      (ireq_valid),
    .o_ireq_addr       (ireq_addr),
    .i_iresp_data_ok   (iresp_data_ok),
    .i_iresp_data      (iresp_data),
    .i_jump_flag       (jump_flag),
    .i_jump_target     (jump_target),
    .i_load_stall      (load_stall),
    .o_dataF_nxt       (dataF_nxt),
    .o_handshake_stall (handshake_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the address being fetched, whether a word is parked for
  // decode, and whether the in-flight response is to be thrown away.
  logic [63:0] m_pc      = 64'h8000_0000;
  logic        m_parked  = 1'b0;
  logic [31:0] m_word    = '0;
  logic        m_drain   = 1'b0;
  logic [63:0] m_redir   = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs after the edge, compare at the falling edge,
  // then advance the model to what the next edge must produce.
  task automatic cycle(input logic rst, input logic ok, input logic [31:0] d,
                       input logic jmp, input logic [63:0] tgt, input logic ls);
    logic        exp_valid;
    logic [31:0] exp_instr;
    @(posedge clk); #1;
    reset = rst; iresp_data_ok = ok; iresp_data = d;
    jump_flag = jmp; jump_target = tgt; load_stall = ls;
    @(negedge clk);
    if (rst) begin
      chk("rst_valid", 64'(dataF_nxt.valid), 64'd0);
      m_pc = 64'h8000_0000; m_parked = 1'b0; m_drain = 1'b0; m_word = '0; m_redir = '0;
    end else begin
      exp_valid = 1'b0;
      exp_instr = '0;
      if (m_parked) begin
        exp_valid = 1'b1; exp_instr = m_word;
      end else if (!m_drain && ok && !jmp && !ls) begin
        exp_valid = 1'b1; exp_instr = d;
      end
      chk("ireq_valid", 64'(ireq_valid), 64'(!m_parked));
      if (!m_parked) chk("ireq_addr", ireq_addr, m_pc);
      chk("stall", 64'(handshake_stall), 64'(!m_parked && !ok));
      chk("out_valid", 64'(dataF_nxt.valid), 64'(exp_valid));
      if (exp_valid) begin
        chk("out_pc", dataF_nxt.pc, m_pc);
        chk("out_instr", 64'(dataF_nxt.raw_instr), 64'(exp_instr));
      end
      if (m_parked) begin
        if (jmp)      begin m_pc = tgt & ~64'd3; m_parked = 1'b0; end
        else if (!ls) begin m_pc = m_pc + 64'd4; m_parked = 1'b0; end
      end else if (m_drain) begin
        if (ok) begin m_pc = m_redir; m_drain = 1'b0; end
      end else if (ok) begin
        if (jmp)     m_pc = tgt & ~64'd3;
        else if (ls) begin m_word = d; m_parked = 1'b1; end
        else         m_pc = m_pc + 64'd4;
      end else if (jmp) begin
        m_redir = tgt & ~64'd3; m_drain = 1'b1;
      end
    end
  endtask

  logic        bus_busy;
  int          wait_left;
  logic        r_rst, r_ok, r_jmp, r_ls, active;
  logic [63:0] r_tgt;

  initial begin
    reset = 1'b1; iresp_data_ok = 1'b0; iresp_data = '0;
    jump_flag = 1'b0; jump_target = '0; load_stall = 1'b0;

    // Reset, then zero-wait stream.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_stall", 64'(handshake_stall), 64'd0);
    cycle(0, 1, 32'h13, 0, 0, 0);
    chk("s0_addr", ireq_addr, 64'h8000_0000);
    chk("s0_instr", 64'(dataF_nxt.raw_instr), 64'h13);
    cycle(0, 1, 32'h93, 0, 0, 0);
    chk("s1_pc", dataF_nxt.pc, 64'h8000_0004);
    cycle(0, 1, 32'h113, 0, 0, 0);
    chk("s2_pc", dataF_nxt.pc, 64'h8000_0008);
    chk("s2_stall", 64'(handshake_stall), 64'd0);

    // Three wait cycles on 0x8000000C.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      chk("w_stall", 64'(handshake_stall), 64'd1);
      chk("w_addr", ireq_addr, 64'h8000_000C);
    end
    cycle(0, 1, 32'h37, 0, 0, 0);
    chk("w_done_valid", 64'(dataF_nxt.valid), 64'd1);

    // Load stall for two cycles on 0x80000010.
    cycle(0, 1, 32'hAB, 0, 0, 1);
    chk("ls_cap_valid", 64'(dataF_nxt.valid), 64'd0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("hold_req", 64'(ireq_valid), 64'd0);
    chk("hold_pc", dataF_nxt.pc, 64'h8000_0010);
    cycle(0, 0, 0, 0, 0, 0);
    chk("hold_instr", 64'(dataF_nxt.raw_instr), 64'hAB);
    cycle(0, 1, 32'h55, 0, 0, 0);
    chk("after_hold_addr", ireq_addr, 64'h8000_0014);

    // Redirect during wait on 0x80000018.
    cycle(0, 0, 0, 1, 64'h8000_1002, 0);
    cycle(0, 0, 0, 1, 64'h8000_1002, 0);
    chk("disc_addr", ireq_addr, 64'h8000_0018);
    cycle(0, 1, 32'hDEAD, 1, 64'h8000_1002, 0);
    chk("disc_drop", 64'(dataF_nxt.valid), 64'd0);
    cycle(0, 1, 32'h99, 0, 0, 0);
    chk("redir_addr", ireq_addr, 64'h8000_1000);

    // Jump together with data_ok, then jump while holding.
    cycle(0, 1, 32'h11, 1, 64'h8000_0200, 0);
    chk("jok_valid", 64'(dataF_nxt.valid), 64'd0);
    cycle(0, 1, 32'h22, 0, 0, 0);
    chk("jok_addr", ireq_addr, 64'h8000_0200);
    cycle(0, 1, 32'h33, 0, 0, 1);
    cycle(0, 0, 0, 1, 64'h8000_0300, 1);
    cycle(0, 1, 32'h44, 0, 0, 0);
    chk("hold_jump_addr", ireq_addr, 64'h8000_0300);
    chk("hold_jump_instr", 64'(dataF_nxt.raw_instr), 64'h44);

    // Reset while discarding.
    cycle(0, 0, 0, 1, 64'h8000_4000, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h66, 0, 0, 0);
    chk("rst_disc_addr", ireq_addr, 64'h8000_0000);
    chk("rst_disc_valid", 64'(dataF_nxt.valid), 64'd1);

    // PC wrap.
    cycle(0, 1, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    cycle(0, 1, 32'h77, 0, 0, 0);
    chk("wrap_top", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(0, 1, 32'h78, 0, 0, 0);
    chk("wrap_zero", ireq_addr, 64'h0);

    // Randomized traffic with a variable-latency bus.
    bus_busy = 1'b0;
    wait_left = 0;
    for (int n = 0; n < 4000; n++) begin
      r_rst  = ($urandom_range(0, 199) == 0);
      active = !r_rst && !m_parked;
      if (active && !bus_busy) begin
        bus_busy  = 1'b1;
        wait_left = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      end
      r_ok  = active && bus_busy && (wait_left == 0);
      r_jmp = ($urandom_range(0, 7) == 0);
      r_ls  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) r_tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else                            r_tgt = 64'h8000_0000 + 64'($urandom_range(0, 16'hFFFF));
      cycle(r_rst, r_ok, $urandom, r_jmp, r_tgt, r_ls);
      if (r_rst || r_ok) bus_busy = 1'b0;
      else if (bus_busy) wait_left--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
